// File: rtl/shift_add_mul.sv
// shift_add_mul -- sequential shift-and-add multiplier.
// Operands are reduced to magnitudes when accepted, multiplied one
// multiplier bit per cycle with an N-bit adder, and the sign is applied
// when the result is written to the product register.
//
// Optional feature macro: MUL_ZERO_SKIP_EN
//   defined   -> a zero operand goes straight to DONE (product 0, done the
//                cycle after accept)
//   undefined -> zero operands take the normal N+1 cycle path
module shift_add_mul #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           a_signed,
  input  logic           b_signed,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  // Counter must hold N-1; one extra bit keeps it comfortable for any N.
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Multiplicand magnitude, held for the whole run.
  logic [N-1:0]   mcand_reg;
  // Upper half: partial sum; lower half: remaining multiplier bits.
  logic [2*N-1:0] acc_reg;
  logic [2*N-1:0] acc_next;
  logic [CW-1:0]  cnt_reg;
  // Sign of the final result, fixed at accept time.
  logic           neg_reg;
  logic [2*N-1:0] product_reg;
  logic [2*N-1:0] product_next;

  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N:0]     sum;
  logic           last_run;
  logic           accept;

`ifdef MUL_ZERO_SKIP_EN
  logic           zero_ops;
`endif

  // A negative operand is negated modulo 2^N; the most negative value
  // maps onto 2^(N-1), which still fits as an unsigned N-bit magnitude.
  assign a_neg = a_signed & a[N-1];
  assign b_neg = b_signed & b[N-1];
  assign a_mag = a_neg ? (N'(0) - a) : a;
  assign b_mag = b_neg ? (N'(0) - b) : b;

`ifdef MUL_ZERO_SKIP_EN
  assign zero_ops = (a == '0) || (b == '0);
`endif

  assign accept   = (state_reg == IDLE) && start;
  assign last_run = (cnt_reg == CW'(N - 1));

  // One shift-add step: add the multiplicand when the multiplier LSB is
  // set, then shift right with the adder carry entering the top bit.
  always_comb begin
    sum = {1'b0, acc_reg[2*N-1:N]} + (acc_reg[0] ? {1'b0, mcand_reg} : {(N+1){1'b0}});
    acc_next = {sum, acc_reg[N-1:1]};
    product_next = neg_reg ? ((2*N)'(0) - acc_next) : acc_next;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start is only looked at in IDLE, so requests made
  // while busy (including the DONE cycle) are dropped, not queued.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
`ifdef MUL_ZERO_SKIP_EN
          state_next = zero_ops ? DONE : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        if (last_run) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, iterate in RUN, publish on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg   <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
      product_reg <= '0;
    end else begin
      if (accept) begin
        mcand_reg <= a_mag;
        acc_reg   <= {{N{1'b0}}, b_mag};
        neg_reg   <= a_neg ^ b_neg;
        cnt_reg   <= '0;
`ifdef MUL_ZERO_SKIP_EN
        if (zero_ops) begin
          product_reg <= '0;
        end
`endif
      end else if (state_reg == RUN) begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + CW'(1);
        if (last_run) begin
          product_reg <= product_next;
        end
      end
    end
  end

  assign product = product_reg;
  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 The block SHALL have parameter N, default 8, operand width in bits (N >= 2).
REQ-002 The block SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, request a multiply; sampled only when busy=0.
REQ-005 The block SHALL have port a, input, N, multiplicand.
REQ-006 The block SHALL have port b, input, N, multiplier.
REQ-007 The block SHALL have port a_signed, input, 1, treat a as two's complement.
REQ-008 The block SHALL have port b_signed, input, 1, treat b as two's complement.
REQ-009 The block SHALL have port product, output, 2N, registered result.
REQ-010 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 The block SHALL have port done, output, 1, one-cycle pulse marking product valid.

Function
REQ-012 The state machine SHALL have states IDLE, RUN, DONE: IDLE->RUN on start; RUN->DONE after N RUN cycles; DONE->IDLE unconditionally.
REQ-013 On the accepting edge, a, b, a_signed, b_signed SHALL be captured; input changes afterwards SHALL not affect the result.
REQ-014 Captured operands SHALL be converted to N-bit magnitudes; for signed -2^(N-1) the magnitude SHALL be 2^(N-1), unsigned, with no overflow.
REQ-015 Result sign SHALL be (a_signed & a[N-1]) XOR (b_signed & b[N-1]).
REQ-016 Each RUN cycle SHALL examine the multiplier LSB: if 1, the N-bit adder SHALL sum the accumulator upper half and the multiplicand magnitude, else it SHALL sum upper half + 0; carry-out SHALL be shifted into bit 2N-1 as the accumulator shifts right by one.
REQ-017 A log2(N)+1-bit counter SHALL count RUN cycles, clear on accept, and exit RUN when it reaches N-1.
REQ-018 Entering DONE, product SHALL be loaded with the accumulator, two's-complement negated over 2N bits if the result sign is 1.
REQ-019 done SHALL be 1 exactly in the DONE cycle, N+1 cycles after the accepting edge.
REQ-020 product SHALL hold its value from DONE until the next DONE; it SHALL not change during RUN.
REQ-021 start while busy=1, including the DONE cycle, SHALL be ignored and SHALL not be queued.
REQ-022 start held high in IDLE SHALL start back-to-back operations, each accepted the cycle after DONE.
REQ-023 Products SHALL be exact for all operand and sign-mode combinations; no truncation or saturation.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, product=0, and clear counter and accumulator.
REQ-025 Reset during RUN or DONE SHALL abandon the operation; no done pulse SHALL follow.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-027 Macro MUL_ZERO_SKIP_EN defined: if either captured operand is zero, the block SHALL go IDLE->DONE directly, product=0, done one cycle after accept.
REQ-028 Macro MUL_ZERO_SKIP_EN undefined: zero operands SHALL take the full N+1-cycle latency, product=0.

Verification (N=8)
REQ-029 Bench: a=255, b=255, unsigned, start -> done 9 cycles later, product=16'hFE01.
REQ-030 Bench: a=8'h80, b=8'hFF, both signed -> product=16'h0080; a=8'hFD signed, b=200 unsigned -> product=16'hFDA8.
REQ-031 Bench: start with a=3, b=5; start again mid-RUN with a=7, b=7 -> single done, product=16'h000F.
REQ-032 Bench: rst_n low for 1 cycle in 4th RUN cycle -> busy=0, product=0 at once, no done within the next 20 cycles.
REQ-033 Bench: a=0, b=77 -> with MUL_ZERO_SKIP_EN, done 1 cycle after accept; without it, done after 9 cycles; product=0 in both.
REQ-034 Bench: 1000 random operand and sign-mode pairs, back-to-back start -> every product matches a 16-bit reference model.
